// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment driver: binary, hex or double-dabble decimal rendering of a DATA_W value.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits in hex and decimal modes.
module seg7_multi_display #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [DATA_W-1:0]          i_data,
  input  logic [1:0]                 i_mode,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [NUM_DIGITS-1:0][6:0] o_HEXs,
  output logic                       o_overflow
);

  localparam int BCD_DIGITS = (DATA_W * 301) / 1000 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int MAXD       = (NUM_DIGITS > DATA_W) ? NUM_DIGITS : DATA_W;
  localparam int SRC_W      = 4 * MAXD;
  localparam int CNT_W      = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                      state_q, state_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic [1:0]                  mode_q, mode_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][6:0]  hex_q, hex_d, enc_hex;
  logic                        ovf_q, ovf_d, enc_ovf;
  logic [SRC_W-1:0]            src;
  logic [3:0]                  nib [NUM_DIGITS];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Handshake: a transfer happens on a rising edge where i_valid && o_ready;
  // i_data/i_mode are captured on that edge, and valid while busy is dropped.
  assign o_ready    = (state_q == IDLE);
  assign o_HEXs     = hex_q;
  assign o_overflow = ovf_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digit extraction and glyph encoding; binary uses one bit per digit.
  always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic seen;
`endif
    src     = (mode_q == 2'd2) ? SRC_W'(bcd_q) : SRC_W'(data_q);
    enc_hex = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib[k] = (mode_q == 2'd0) ? {3'b000, src[k]} : src[4*k +: 4];
    end
    enc_ovf = (mode_q == 2'd0) ? |(src >> NUM_DIGITS) : |(src >> (4 * NUM_DIGITS));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Hidden nonzero digits above the shown ones mean nothing shown is "leading".
    seen = enc_ovf;
`endif
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      enc_hex[k] = glyph(nib[k]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if ((mode_q != 2'd0) && (k != 0) && !seen && (nib[k] == 4'd0)) enc_hex[k] = 7'h7F;
      if (nib[k] != 4'd0) seen = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          data_d  = i_data;
          mode_d  = i_mode;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = (i_mode == 2'd2) ? CONV : LOAD;
        end
      end
      CONV: begin
        // data_q doubles as the double-dabble input shifter.
        bcd_d  = {bcd_adj[BCD_W-2:0], data_q[DATA_W-1]};
        data_d = data_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = LOAD;
      end
      LOAD: begin
        hex_d   = enc_hex;
        ovf_d   = enc_ovf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= '1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench for seg7_multi_display: a 16-bit/5-digit instance and a 17-bit/3-digit instance.
module tb_seg7_multi_display;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam int LZ = -1;
`else
  localparam int LZ = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       data1;
  logic [1:0]        mode1;
  logic              valid1;
  logic              ready1;
  logic [4:0][6:0]   hex1;
  logic              ovf1;
  logic [16:0]       data2;
  logic [1:0]        mode2;
  logic              valid2;
  logic              ready2;
  logic [2:0][6:0]   hex2;
  logic              ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_multi_display #(.DATA_W(16), .NUM_DIGITS(5)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data1), .i_mode(mode1), .i_valid(valid1),
    .o_ready(ready1), .o_HEXs(hex1), .o_overflow(ovf1)
  );

  seg7_multi_display #(.DATA_W(17), .NUM_DIGITS(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_mode(mode2), .i_valid(valid2),
    .o_ready(ready2), .o_HEXs(hex2), .o_overflow(ovf2)
  );

  function automatic logic [6:0] g(input int d);
    case (d)
      0:  g = 7'b1000000;
      1:  g = 7'b1111001;
      2:  g = 7'b0100100;
      3:  g = 7'b0110000;
      4:  g = 7'b0011001;
      5:  g = 7'b0010010;
      6:  g = 7'b0000010;
      7:  g = 7'b1111000;
      8:  g = 7'b0000000;
      9:  g = 7'b0010000;
      10: g = 7'b0001000;
      11: g = 7'b0000011;
      12: g = 7'b1000110;
      13: g = 7'b0100001;
      14: g = 7'b0000110;
      15: g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
  endfunction

  function automatic logic [63:0] e5(input int a4, input int a3, input int a2, input int a1, input int a0);
    e5 = {29'b0, g(a4), g(a3), g(a2), g(a1), g(a0)};
  endfunction

  function automatic logic [63:0] e3(input int a2, input int a1, input int a0);
    e3 = {43'b0, g(a2), g(a1), g(a0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the target idle; returns at the first negedge with ready high again.
  task automatic send(input bit sel, input logic [16:0] data, input logic [1:0] mode,
                      input int exp_busy, input int poke_at, input string tag);
    int busy;
    bit rdy;
    rdy = sel ? ready2 : ready1;
    check({tag, "_ready_in"}, 64'(rdy), 64'd1);
    if (sel) begin
      data2 = data; mode2 = mode; valid2 = 1'b1;
    end else begin
      data1 = data[15:0]; mode1 = mode; valid1 = 1'b1;
    end
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
    busy = 0;
    for (int n = 0; n < 60; n++) begin
      rdy = sel ? ready2 : ready1;
      if (rdy) break;
      busy++;
      if (busy == poke_at) begin
        data1 = ~data[15:0]; mode1 = 2'd1; valid1 = !sel;
        data2 = ~data;       mode2 = 2'd1; valid2 = sel;
      end else begin
        valid1 = 1'b0;
        valid2 = 1'b0;
      end
      @(negedge clk);
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid1 = 1'b0; data1 = '0; mode1 = '0;
    valid2 = 1'b0; data2 = '0; mode2 = '0;
    repeat (3) @(negedge clk);
    check("rst_hex", 64'(hex1), {29'b0, {35{1'b1}}});
    check("rst_ovf", 64'(ovf1), 64'd0);
    check("rst_hex2", 64'(hex2), {43'b0, {21{1'b1}}});
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready1), 64'd1);

    send(1'b0, 17'h00016, 2'd0, 1, 0, "bin16");
    check("bin16_hex", 64'(hex1), e5(1, 0, 1, 1, 0));
    check("bin16_ovf", 64'(ovf1), 64'd0);

    send(1'b0, 17'h0BEEF, 2'd1, 1, 0, "hexbeef");
    check("hexbeef_hex", 64'(hex1), e5(LZ, 11, 14, 14, 15));
    check("hexbeef_ovf", 64'(ovf1), 64'd0);

    send(1'b0, 17'h000A5, 2'd3, 1, 0, "mode3");
    check("mode3_hex", 64'(hex1), e5(LZ, LZ, LZ, 10, 5));

    send(1'b0, 17'h00000, 2'd1, 1, 0, "hex0");
    check("hex0_hex", 64'(hex1), e5(LZ, LZ, LZ, LZ, 0));

    send(1'b0, 17'd65535, 2'd2, 17, 0, "dec65535");
    check("dec65535_hex", 64'(hex1), e5(6, 5, 5, 3, 5));
    check("dec65535_ovf", 64'(ovf1), 64'd0);

    send(1'b0, 17'd0, 2'd2, 17, 0, "dec0");
    check("dec0_hex", 64'(hex1), e5(LZ, LZ, LZ, LZ, 0));

    send(1'b0, 17'd1234, 2'd2, 17, 0, "dec1234");
    check("dec1234_hex", 64'(hex1), e5(LZ, 1, 2, 3, 4));

    send(1'b0, 17'h00020, 2'd0, 1, 0, "bin20");
    check("bin20_hex", 64'(hex1), e5(0, 0, 0, 0, 0));
    check("bin20_ovf", 64'(ovf1), 64'd1);

    send(1'b1, 17'd123456, 2'd2, 18, 0, "d2dec");
    check("d2dec_hex", 64'(hex2), e3(4, 5, 6));
    check("d2dec_ovf", 64'(ovf2), 64'd1);

    send(1'b1, 17'h10003, 2'd0, 1, 0, "d2bin");
    check("d2bin_hex", 64'(hex2), e3(0, 1, 1));
    check("d2bin_ovf", 64'(ovf2), 64'd1);

    send(1'b1, 17'h00ABC, 2'd1, 1, 0, "d2hex");
    check("d2hex_hex", 64'(hex2), e3(10, 11, 12));
    check("d2hex_ovf", 64'(ovf2), 64'd0);

    // Extra valid pulse while converting must be dropped.
    send(1'b0, 17'd54321, 2'd2, 17, 3, "poke");
    check("poke_hex", 64'(hex1), e5(5, 4, 3, 2, 1));
    repeat (20) @(negedge clk);
    check("poke_hold_hex", 64'(hex1), e5(5, 4, 3, 2, 1));
    check("poke_hold_ready", 64'(ready1), 64'd1);

    // Reset during CONV abandons the conversion.
    data1 = 16'd99; mode1 = 2'd2; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (4) @(negedge clk);
    check("midconv_busy", 64'(ready1), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hex", 64'(hex1), {29'b0, {35{1'b1}}});
    check("midrst_ovf", 64'(ovf1), 64'd0);
    check("midrst_ready", 64'(ready1), 64'd1);
    repeat (25) @(negedge clk);
    check("midrst_late_hex", 64'(hex1), {29'b0, {35{1'b1}}});
    check("midrst_late_ready", 64'(ready1), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
